// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and stage-control unit for a 5-stage MIPS pipeline. It decides,
//   every cycle, which latches advance, which load a bubble, and whether the
//   PC updates. It also sequences a halt (a drain period, then a sticky halt)
//   and keeps saturating stall and flush statistics.
//
// Parameters
//   DRAIN_CYCLES  cycles spent in DRAIN before HALTED (>=1)
//   CNT_W         width of stall_cnt / flush_cnt
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   ihit, dhit                    I-cache / D-cache completion
//   ifid_rs, ifid_rt              source regs of the instruction in IF/ID
//   idex_rt, idex_MemRead         load destination / load flag in ID/EX
//   ex_jump                       jump resolved in EX
//   exmem_MemRead/MemWrite        load / store sitting in EX/MEM
//   exmem_brtaken, exmem_halt     taken branch / HALT in EX/MEM
//   pc_en, *_en                   PC and latch enables
//   *_flush                       load a bubble into the latch on next edge
//   dmem_ren, dmem_wen            D-cache requests
//   halt                          registered, sticky once HALTED is reached
//   stall_cnt, flush_cnt          saturating RUN-state statistics
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_MemRead,
    input  logic             ex_jump,
    input  logic             exmem_MemRead,
    input  logic             exmem_MemWrite,
    input  logic             exmem_brtaken,
    input  logic             exmem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             dmem_ren,
    output logic             dmem_wen,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t        state, state_n;
    logic [DW-1:0] drain_cnt, drain_n;
    logic          dstall, load_use, any_flush;

    // Memory stage is waiting on the D-cache: nothing may move.
    assign dstall   = (exmem_MemRead | exmem_MemWrite) & ~dhit;
    // $0 is never a real dependency, so a load into $0 never stalls.
    assign load_use = idex_MemRead & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign any_flush = ifid_flush | idex_flush | exmem_flush;

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        dmem_ren    = 1'b0;
        dmem_wen    = 1'b0;
        state_n     = state;
        drain_n     = drain_cnt;
        // While reset is held every control output stays low.
        if (!RST) begin
            unique case (state)
                RUN: begin
                    dmem_ren = exmem_MemRead;
                    dmem_wen = exmem_MemWrite;
                    if (dstall) begin
                        // freeze: all enables already 0
                    end else if (exmem_halt) begin
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_n     = DRAIN;
                        drain_n     = '0;
                    end else if (exmem_brtaken) begin
                        // Branch beats load-use: the stalled bubble is flushed anyway.
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (ex_jump) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, insert a bubble into ID/EX.
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        // No new instruction: bubble into IF/ID, older ones drain.
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                    end
                end
                DRAIN: begin
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state_n = HALTED;
                        drain_n = '0;
                    end else begin
                        drain_n = drain_cnt + 1'b1;
                    end
                end
                HALTED: begin
                    // everything parked until reset
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
            halt      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
            if (state_n == HALTED)
                halt <= 1'b1;
            if (state == RUN) begin
                if (!pc_en && (stall_cnt != '1))
                    stall_cnt <= stall_cnt + 1'b1;
                if (any_flush && (flush_cnt != '1))
                    flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Control outputs are packed as
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//  ifid_flush, idex_flush, exmem_flush, dmem_ren, dmem_wen}.
// Inputs change just after the falling edge; combinational outputs are
// sampled 1ns later and registered outputs after the following falling edge.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ihit, dhit, idex_MemRead, ex_jump;
    logic          exmem_MemRead, exmem_MemWrite, exmem_brtaken, exmem_halt;
    logic [4:0]    ifid_rs, ifid_rt, idex_rt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, dmem_ren, dmem_wen, halt;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [9:0]    ctl;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [9:0] ALL   = 10'b11111_111_11;
    localparam logic [9:0] NORM  = 10'b11111_000_00;
    localparam logic [9:0] LU    = 10'b00111_010_00;
    localparam logic [9:0] DRN   = 10'b00001_111_00;
    localparam logic [9:0] DRN_M = 10'b10001_111_11; // ifid/idex/exmem enables don't care
    localparam logic [9:0] IMISS = 10'b01111_100_00;
    localparam logic [9:0] IM_M  = 10'b10111_111_11; // ifid_en don't care

    pipeline_ctrl #(.DRAIN_CYCLES(1), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
        .idex_MemRead(idex_MemRead), .ex_jump(ex_jump),
        .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
        .exmem_brtaken(exmem_brtaken), .exmem_halt(exmem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, dmem_ren, dmem_wen};

    always #5 CLK = ~CLK;

    task automatic chk_ctl(input string tag, input logic [9:0] exp, input logic [9:0] mask);
        n_chk++;
        assert ((ctl & mask) === (exp & mask)) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b (mask %b)", tag, ctl, exp, mask);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input int st, input int fl, input logic h);
        chk_val({tag, ".stall_cnt"}, 32'(stall_cnt), st);
        chk_val({tag, ".flush_cnt"}, 32'(flush_cnt), fl);
        chk_val({tag, ".halt"}, {31'd0, halt}, {31'd0, h});
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
        idex_MemRead = 1'b0; ex_jump = 1'b0; exmem_MemRead = 1'b0;
        exmem_MemWrite = 1'b0; exmem_brtaken = 1'b0; exmem_halt = 1'b0;
    endtask

    // Called just after a falling edge: reset asserted mid-cycle, checked at once.
    task automatic rst_pulse(input string tag);
        #2 RST = 1'b1;
        #1;
        chk_ctl({tag, ".ctl"}, 10'b0, ALL);
        chk_regs(tag, 0, 0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        idle();
        @(negedge CLK);
        ihit = 1'b1;
        rst_pulse("reset0");

        // normal flow
        idle(); #1 chk_ctl("normal", NORM, ALL);
        @(negedge CLK); chk_regs("normal", 0, 0, 1'b0);

        // lw $2 ; add $3,$2,$4
        idle(); idex_MemRead = 1; idex_rt = 5'd2; ifid_rs = 5'd2;
        #1 chk_ctl("lu_rs", LU, ALL);
        @(negedge CLK); chk_regs("lu_rs", 1, 1, 1'b0);

        // load into $0 never stalls
        idle(); idex_MemRead = 1; idex_rt = 5'd0; ifid_rs = 5'd0;
        #1 chk_ctl("lu_r0", NORM, ALL);
        @(negedge CLK);

        // rt match
        idle(); idex_MemRead = 1; idex_rt = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd7;
        #1 chk_ctl("lu_rt", LU, ALL);
        @(negedge CLK); chk_regs("lu_rt", 2, 2, 1'b0);

        // matching regs but not a load
        idle(); idex_rt = 5'd5; ifid_rs = 5'd5;
        #1 chk_ctl("no_load", NORM, ALL);
        @(negedge CLK);

        // load miss for 3 cycles
        for (int i = 0; i < 3; i++) begin
            idle(); exmem_MemRead = 1; dhit = 0;
            #1 chk_ctl($sformatf("dstall%0d", i), 10'b00000_000_10, ALL);
            @(negedge CLK);
        end
        chk_regs("dstall", 5, 2, 1'b0);
        idle(); exmem_MemRead = 1; dhit = 1;
        #1 chk_ctl("dhit", 10'b11111_000_10, ALL);
        @(negedge CLK); chk_regs("dhit", 5, 2, 1'b0);

        // store miss
        idle(); exmem_MemWrite = 1;
        #1 chk_ctl("st_miss", 10'b00000_000_01, ALL);
        @(negedge CLK); chk_regs("st_miss", 6, 2, 1'b0);

        // taken branch beats load-use
        idle(); exmem_brtaken = 1; idex_MemRead = 1; idex_rt = 5'd2; ifid_rs = 5'd2;
        #1 chk_ctl("br_lu", 10'b11111_111_00, ALL);
        @(negedge CLK); chk_regs("br_lu", 6, 3, 1'b0);

        // dstall masks branch, branch taken once dhit arrives
        idle(); exmem_brtaken = 1; exmem_MemRead = 1;
        #1 chk_ctl("br_dstall", 10'b00000_000_10, ALL);
        @(negedge CLK); chk_regs("br_dstall", 7, 3, 1'b0);
        dhit = 1;
        #1 chk_ctl("br_dhit", 10'b11111_111_10, ALL);
        @(negedge CLK); chk_regs("br_dhit", 7, 4, 1'b0);

        // jump beats load-use
        idle(); ex_jump = 1; idex_MemRead = 1; idex_rt = 5'd3; ifid_rt = 5'd3;
        #1 chk_ctl("jump_lu", 10'b11111_110_00, ALL);
        @(negedge CLK); chk_regs("jump_lu", 7, 5, 1'b0);

        // I-cache miss
        idle(); ihit = 0;
        #1 chk_ctl("imiss", IMISS, IM_M);
        @(negedge CLK); chk_regs("imiss", 8, 6, 1'b0);

        // dstall masks halt; still in RUN afterwards
        idle(); exmem_halt = 1; exmem_MemRead = 1;
        #1 chk_ctl("halt_dstall", 10'b00000_000_10, ALL);
        @(negedge CLK); chk_regs("halt_dstall", 9, 6, 1'b0);
        idle(); #1 chk_ctl("still_run", NORM, ALL);
        @(negedge CLK);

        // saturation with CNT_W=4
        rst_pulse("reset_sat");
        for (int i = 0; i < 20; i++) begin
            idle(); ihit = 0;
            @(negedge CLK);
            if (i == 14) chk_regs("sat15", 15, 15, 1'b0);
        end
        chk_regs("sat20", 15, 15, 1'b0);

        // halt sequence
        rst_pulse("reset_halt");
        idle(); exmem_halt = 1;
        #1 chk_ctl("halt_run", DRN, DRN_M);
        @(negedge CLK); chk_regs("halt_run", 1, 1, 1'b0);
        idle();
        #1 chk_ctl("drain", DRN, DRN_M);
        @(negedge CLK); chk_regs("drain", 1, 1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle();
            ihit = i[0]; dhit = i[1]; exmem_MemRead = 1; exmem_MemWrite = i[0];
            exmem_brtaken = ~i[0]; ex_jump = 1; exmem_halt = i[1];
            idex_MemRead = 1; idex_rt = 5'd4; ifid_rs = 5'd4;
            #1 chk_ctl($sformatf("halted%0d", i), 10'b0, ALL);
            @(negedge CLK); chk_regs($sformatf("halted%0d", i), 1, 1, 1'b1);
        end

        // reset in the middle of DRAIN
        idle();
        rst_pulse("reset_pre_drain");
        idle(); exmem_halt = 1;
        @(negedge CLK);
        idle();
        #1 chk_ctl("drain2", DRN, DRN_M);
        rst_pulse("reset_mid_drain");
        idle();
        #1 chk_ctl("after_rst", NORM, ALL);
        @(negedge CLK); chk_regs("after_rst", 0, 0, 1'b0);
        #1 chk_ctl("after_rst2", NORM, ALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
